// File: rtl/matrix_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : matrix_multiplier
// Description : Serial-load 3x3 by 3x3 unsigned matrix multiplier.
//               Eighteen ic edges shift in A then B (4-bit elements,
//               row-major). Nine further edges compute C = A*B, one
//               element per edge. The machine then parks in DONE until
//               mr. Any C element can be read combinationally via os/en.
//
// Ports       : ic     - clock; all state advances on the rising edge
//               mr     - master reset, asynchronous, active-high
//               i      - operand element data (4 bits), sampled in LOAD
//               os     - output select, 0..8 = row*3+col
//               en     - output enable
//               matrix - selected result element C[os] (10 bits)
//
// Option      : MATMUL_TRISTATE_OUT_EN - when defined, matrix floats
//               (high-impedance) while en = 0 so it can share a bus;
//               otherwise matrix is driven to 0 while en = 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_multiplier (
    input  logic       ic,
    input  logic       mr,
    input  logic [3:0] i,
    input  logic [3:0] os,
    input  logic       en,
    output logic [9:0] matrix
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [4:0] C_LOAD_LAST = 5'd17;
    localparam logic [4:0] C_B_FIRST   = 5'd9;
    localparam logic [3:0] C_COMP_LAST = 4'd8;

    state_t     r_state;
    state_t     w_state_next;

    logic [4:0] r_load_cnt;
    logic [3:0] r_comp_cnt;

    logic [3:0] r_a [0:8];
    logic [3:0] r_b [0:8];
    logic [9:0] r_c [0:8];

    logic       w_load_a;
    logic       w_load_b;
    logic       w_c_we;
    logic [3:0] w_b_idx;

    logic [1:0] w_row;
    logic [1:0] w_col;
    logic [3:0] w_a0, w_a1, w_a2;
    logic [3:0] w_b0, w_b1, w_b2;
    logic [7:0] w_p0, w_p1, w_p2;
    logic [9:0] w_sum;
    logic [9:0] w_c_sel;

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_c_we       = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (r_load_cnt < C_B_FIRST) begin
                    w_load_a = 1'b1;
                end else begin
                    w_load_b = 1'b1;
                end
                if (r_load_cnt == C_LOAD_LAST) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                w_c_we = 1'b1;
                if (r_comp_cnt == C_COMP_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge ic or posedge mr) begin
        if (mr) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Element counters; each parks on its last value rather than wrapping
    // ------------------------------------------------------------------
    always_ff @(posedge ic or posedge mr) begin
        if (mr) begin
            r_load_cnt <= '0;
            r_comp_cnt <= '0;
        end else begin
            if (r_state == S_LOAD && r_load_cnt != C_LOAD_LAST) begin
                r_load_cnt <= r_load_cnt + 5'd1;
            end
            if (r_state == S_COMPUTE && r_comp_cnt != C_COMP_LAST) begin
                r_comp_cnt <= r_comp_cnt + 4'd1;
            end
        end
    end

    // B index = load count - 9. Working modulo 16 on the low four bits
    // gives the right answer for counts 9..17 (16 -> 7, 17 -> 8).
    assign w_b_idx = r_load_cnt[3:0] - 4'd9;

    // ------------------------------------------------------------------
    // Operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge ic or posedge mr) begin
        if (mr) begin
            for (int k = 0; k < 9; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            if (w_load_a) begin
                r_a[r_load_cnt[3:0]] <= i;
            end
            if (w_load_b) begin
                r_b[w_b_idx] <= i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result element decode: compute count -> (row, col)
    // ------------------------------------------------------------------
    always_comb begin
        w_row = 2'd0;
        w_col = 2'd0;
        case (r_comp_cnt)
            4'd0: begin w_row = 2'd0; w_col = 2'd0; end
            4'd1: begin w_row = 2'd0; w_col = 2'd1; end
            4'd2: begin w_row = 2'd0; w_col = 2'd2; end
            4'd3: begin w_row = 2'd1; w_col = 2'd0; end
            4'd4: begin w_row = 2'd1; w_col = 2'd1; end
            4'd5: begin w_row = 2'd1; w_col = 2'd2; end
            4'd6: begin w_row = 2'd2; w_col = 2'd0; end
            4'd7: begin w_row = 2'd2; w_col = 2'd1; end
            4'd8: begin w_row = 2'd2; w_col = 2'd2; end
            default: begin w_row = 2'd0; w_col = 2'd0; end
        endcase
    end

    // Row of A selected by w_row
    always_comb begin
        w_a0 = '0;
        w_a1 = '0;
        w_a2 = '0;
        case (w_row)
            2'd0:    begin w_a0 = r_a[0]; w_a1 = r_a[1]; w_a2 = r_a[2]; end
            2'd1:    begin w_a0 = r_a[3]; w_a1 = r_a[4]; w_a2 = r_a[5]; end
            2'd2:    begin w_a0 = r_a[6]; w_a1 = r_a[7]; w_a2 = r_a[8]; end
            default: begin w_a0 = '0;     w_a1 = '0;     w_a2 = '0;     end
        endcase
    end

    // Column of B selected by w_col
    always_comb begin
        w_b0 = '0;
        w_b1 = '0;
        w_b2 = '0;
        case (w_col)
            2'd0:    begin w_b0 = r_b[0]; w_b1 = r_b[3]; w_b2 = r_b[6]; end
            2'd1:    begin w_b0 = r_b[1]; w_b1 = r_b[4]; w_b2 = r_b[7]; end
            2'd2:    begin w_b0 = r_b[2]; w_b1 = r_b[5]; w_b2 = r_b[8]; end
            default: begin w_b0 = '0;     w_b1 = '0;     w_b2 = '0;     end
        endcase
    end

    // ------------------------------------------------------------------
    // Three 4x4 multipliers and the 3-input adder. Max sum 3*225 = 675
    // fits in 10 bits, so no saturation is needed.
    // ------------------------------------------------------------------
    assign w_p0  = {4'd0, w_a0} * {4'd0, w_b0};
    assign w_p1  = {4'd0, w_a1} * {4'd0, w_b1};
    assign w_p2  = {4'd0, w_a2} * {4'd0, w_b2};
    assign w_sum = {2'd0, w_p0} + {2'd0, w_p1} + {2'd0, w_p2};

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge ic or posedge mr) begin
        if (mr) begin
            for (int k = 0; k < 9; k++) begin
                r_c[k] <= '0;
            end
        end else if (w_c_we) begin
            r_c[r_comp_cnt] <= w_sum;
        end
    end

    // ------------------------------------------------------------------
    // Output select: indices 9..15 read as 0
    // ------------------------------------------------------------------
    always_comb begin
        w_c_sel = '0;
        case (os)
            4'd0:    w_c_sel = r_c[0];
            4'd1:    w_c_sel = r_c[1];
            4'd2:    w_c_sel = r_c[2];
            4'd3:    w_c_sel = r_c[3];
            4'd4:    w_c_sel = r_c[4];
            4'd5:    w_c_sel = r_c[5];
            4'd6:    w_c_sel = r_c[6];
            4'd7:    w_c_sel = r_c[7];
            4'd8:    w_c_sel = r_c[8];
            default: w_c_sel = '0;
        endcase
    end

`ifdef MATMUL_TRISTATE_OUT_EN
    assign matrix = en ? w_c_sel : 10'bz;
`else
    assign matrix = en ? w_c_sel : 10'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_multiplier
// Description : Self-checking bench for matrix_multiplier. Clock pulses are
//               issued one at a time so every ic edge is deliberate. Expected
//               results come from a plain-arithmetic matrix product model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_multiplier;

    logic       ic = 1'b0;
    logic       mr = 1'b0;
    logic [3:0] i  = 4'd0;
    logic [3:0] os = 4'd0;
    logic       en = 1'b0;
    wire  [9:0] matrix;

    int checks   = 0;
    int failures = 0;

    int ma [9];
    int mb [9];
    int ref_c [9] = '{72, 82, 63, 117, 132, 97, 0, 0, 0};

`ifdef MATMUL_TRISTATE_OUT_EN
    localparam logic [9:0] C_DIS = 10'bz;
`else
    localparam logic [9:0] C_DIS = 10'd0;
`endif

    matrix_multiplier dut (
        .ic     (ic),
        .mr     (mr),
        .i      (i),
        .os     (os),
        .en     (en),
        .matrix (matrix)
    );

    // Reference: C[n] = sum_j A[r][j]*B[j][c], r = n/3, c = n%3
    function automatic int model_c(input int n);
        int s;
        s = 0;
        for (int j = 0; j < 3; j++) begin
            s += ma[(n / 3) * 3 + j] * mb[j * 3 + (n % 3)];
        end
        return s;
    endfunction

    // One rising edge of ic with data d held around it
    task automatic pulse(input logic [3:0] d);
        i  = d;
        #2 ic = 1'b1;
        #3 ic = 1'b0;
        #5;
    endtask

    task automatic do_reset();
        mr = 1'b1;
        #3;
        mr = 1'b0;
        #2;
    endtask

    task automatic load_ops();
        for (int k = 0; k < 9; k++) pulse(ma[k][3:0]);
        for (int k = 0; k < 9; k++) pulse(mb[k][3:0]);
    endtask

    task automatic set_reference();
        int a [9] = '{1, 4, 5, 4, 5, 6, 0, 0, 0};
        int b [9] = '{10, 11, 7, 13, 14, 9, 2, 3, 4};
        for (int k = 0; k < 9; k++) begin
            ma[k] = a[k];
            mb[k] = b[k];
        end
    endtask

    task automatic test_reset();
        mr = 1'b1;
        en = 1'b1;
        #2;
        // edges during reset must do nothing
        for (int k = 0; k < 3; k++) pulse(4'hF);
        for (int s = 0; s < 16; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== 10'd0) begin
                failures++;
                $display("FAIL reset_hold os=%0d got=%0d want=0", s, matrix);
            end
        end
        mr = 1'b0;
        #2;
        for (int s = 0; s < 9; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== 10'd0) begin
                failures++;
                $display("FAIL reset_state os=%0d got=%0d want=0", s, matrix);
            end
        end
    endtask

    task automatic test_reference();
        set_reference();
        do_reset();
        load_ops();
        for (int k = 0; k < 9; k++) pulse(4'h0);
        en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== ref_c[s][9:0]) begin
                failures++;
                $display("FAIL reference os=%0d got=%0d want=%0d", s, matrix, ref_c[s]);
            end
        end
    endtask

    task automatic test_output_enable();
        en = 1'b0;
        for (int s = 0; s < 9; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== C_DIS) begin
                failures++;
                $display("FAIL enable_off os=%0d got=%b want=%b", s, matrix, C_DIS);
            end
        end
        en = 1'b1;
        for (int s = 9; s < 16; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== 10'd0) begin
                failures++;
                $display("FAIL select_range os=%0d got=%0d want=0", s, matrix);
            end
        end
    endtask

    task automatic test_done_hold();
        for (int k = 0; k < 5; k++) pulse(4'hF);
        en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== ref_c[s][9:0]) begin
                failures++;
                $display("FAIL done_hold os=%0d got=%0d want=%0d", s, matrix, ref_c[s]);
            end
        end
    endtask

    task automatic test_max();
        for (int k = 0; k < 9; k++) begin
            ma[k] = 15;
            mb[k] = 15;
        end
        do_reset();
        load_ops();
        for (int k = 0; k < 9; k++) pulse(4'h0);
        en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== 10'd675) begin
                failures++;
                $display("FAIL max_value os=%0d got=%0d want=675", s, matrix);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_reference();
        do_reset();
        for (int k = 0; k < 9; k++) pulse(ma[k][3:0]);
        pulse(mb[0][3:0]);
        mr = 1'b1;
        en = 1'b1;
        #2;
        for (int s = 0; s < 16; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== 10'd0) begin
                failures++;
                $display("FAIL reset_mid_clear os=%0d got=%0d want=0", s, matrix);
            end
        end
        mr = 1'b0;
        #2;
        load_ops();
        for (int k = 0; k < 9; k++) pulse(4'h0);
        for (int s = 0; s < 9; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== ref_c[s][9:0]) begin
                failures++;
                $display("FAIL reset_mid_reload os=%0d got=%0d want=%0d", s, matrix, ref_c[s]);
            end
        end
    endtask

    task automatic test_incremental();
        int want [9] = '{72, 82, 63, 117, 0, 0, 0, 0, 0};
        set_reference();
        do_reset();
        load_ops();
        for (int k = 0; k < 4; k++) pulse(4'h0);
        en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            os = s[3:0];
            #1;
            checks++;
            if (matrix !== want[s][9:0]) begin
                failures++;
                $display("FAIL incremental os=%0d got=%0d want=%0d", s, matrix, want[s]);
            end
        end
    endtask

    // Random operands; after every compute pulse, elements already
    // computed must match the model and later ones must still read 0.
    task automatic test_random();
        int want;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 9; k++) begin
                ma[k] = int'($urandom_range(0, 15));
                mb[k] = int'($urandom_range(0, 15));
            end
            do_reset();
            load_ops();
            en = 1'b1;
            for (int n = 0; n < 9; n++) begin
                pulse(4'(($urandom_range(0, 15))));
                for (int s = 0; s < 9; s++) begin
                    os = s[3:0];
                    #1;
                    want = (s <= n) ? model_c(s) : 0;
                    checks++;
                    if (matrix !== want[9:0]) begin
                        failures++;
                        $display("FAIL random it=%0d step=%0d os=%0d got=%0d want=%0d",
                                 it, n, s, matrix, want);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reference();
        test_output_enable();
        test_done_hold();
        test_max();
        test_reset_mid();
        test_incremental();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
